// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants and helpers shared by the
// sync generator and the output controller.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 11;

    localparam int unsigned DEF_H_SYNC  = 96;
    localparam int unsigned DEF_H_BACK  = 48;
    localparam int unsigned DEF_H_ACT   = 640;
    localparam int unsigned DEF_H_FRONT = 16;
    localparam int unsigned DEF_V_SYNC  = 2;
    localparam int unsigned DEF_V_BACK  = 33;
    localparam int unsigned DEF_V_ACT   = 480;
    localparam int unsigned DEF_V_FRONT = 10;

    function automatic int unsigned axis_total(input int unsigned sync, input int unsigned back,
                                               input int unsigned act, input int unsigned front);
        return sync + back + act + front;
    endfunction

    localparam int unsigned H_TOTAL     = axis_total(DEF_H_SYNC, DEF_H_BACK, DEF_H_ACT, DEF_H_FRONT);
    localparam int unsigned V_TOTAL     = axis_total(DEF_V_SYNC, DEF_V_BACK, DEF_V_ACT, DEF_V_FRONT);
    localparam int unsigned H_ACT_FIRST = DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned H_ACT_LAST  = H_ACT_FIRST + DEF_H_ACT - 1;
    localparam int unsigned V_ACT_FIRST = DEF_V_SYNC + DEF_V_BACK;
    localparam int unsigned V_ACT_LAST  = V_ACT_FIRST + DEF_V_ACT - 1;

endpackage

// File: rtl/vga_sync_gen.sv
// H/V raster counters with region decode; all outputs registered and aligned
// to the counter values of the same cycle (stage 0).
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_SYNC  = DEF_H_SYNC,
    parameter int unsigned H_BACK  = DEF_H_BACK,
    parameter int unsigned H_ACT   = DEF_H_ACT,
    parameter int unsigned H_FRONT = DEF_H_FRONT,
    parameter int unsigned V_SYNC  = DEF_V_SYNC,
    parameter int unsigned V_BACK  = DEF_V_BACK,
    parameter int unsigned V_ACT   = DEF_V_ACT,
    parameter int unsigned V_FRONT = DEF_V_FRONT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic             req_o,
    output logic [CNT_W-1:0] x_o,
    output logic [CNT_W-1:0] y_o,
    output logic             hs_n_o,
    output logic             vs_n_o,
    output logic             frame_start_o
);

    localparam logic [CNT_W-1:0] HLast     = CNT_W'(axis_total(H_SYNC, H_BACK, H_ACT, H_FRONT) - 1);
    localparam logic [CNT_W-1:0] VLast     = CNT_W'(axis_total(V_SYNC, V_BACK, V_ACT, V_FRONT) - 1);
    localparam logic [CNT_W-1:0] HActFirst = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] HActLast  = CNT_W'(H_SYNC + H_BACK + H_ACT - 1);
    localparam logic [CNT_W-1:0] VActFirst = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] VActLast  = CNT_W'(V_SYNC + V_BACK + V_ACT - 1);
    localparam logic [CNT_W-1:0] HSyncEnd  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VSyncEnd  = CNT_W'(V_SYNC);

    logic             run_q;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             req_q, req_d, hs_n_q, hs_n_d, vs_n_q, vs_n_d, fs_q, fs_d;

    // Counters hold on the first edge after reset so that the first running
    // cycle presents the frame origin together with the frame-start pulse.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (run_q) begin
            if (h_q == HLast) begin
                h_d = '0;
                v_d = (v_q == VLast) ? '0 : v_q + CNT_W'(1);
            end else begin
                h_d = h_q + CNT_W'(1);
            end
        end
        req_d  = (h_d >= HActFirst) && (h_d <= HActLast) &&
                 (v_d >= VActFirst) && (v_d <= VActLast);
        x_d    = req_d ? h_d - HActFirst : '0;
        y_d    = req_d ? v_d - VActFirst : '0;
        hs_n_d = !(h_d < HSyncEnd);
        vs_n_d = !(v_d < VSyncEnd);
        fs_d   = (h_d == '0) && (v_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q  <= 1'b0;
            h_q    <= '0;
            v_q    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            req_q  <= 1'b0;
            hs_n_q <= 1'b1;
            vs_n_q <= 1'b1;
            fs_q   <= 1'b0;
        end else begin
            run_q  <= 1'b1;
            h_q    <= h_d;
            v_q    <= v_d;
            x_q    <= x_d;
            y_q    <= y_d;
            req_q  <= req_d;
            hs_n_q <= hs_n_d;
            vs_n_q <= vs_n_d;
            fs_q   <= fs_d;
        end
    end

    assign req_o         = req_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign hs_n_o        = hs_n_q;
    assign vs_n_o        = vs_n_q;
    assign frame_start_o = fs_q;

endmodule

// File: rtl/vga_out_ctrl.sv
// VGA output controller: requests pixels from upstream and delays sync and
// blanking by two cycles so they line up with the returned pixel data.
module vga_out_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_SYNC  = DEF_H_SYNC,
    parameter int unsigned H_BACK  = DEF_H_BACK,
    parameter int unsigned H_ACT   = DEF_H_ACT,
    parameter int unsigned H_FRONT = DEF_H_FRONT,
    parameter int unsigned V_SYNC  = DEF_V_SYNC,
    parameter int unsigned V_BACK  = DEF_V_BACK,
    parameter int unsigned V_ACT   = DEF_V_ACT,
    parameter int unsigned V_FRONT = DEF_V_FRONT
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic [9:0]       iRed,
    input  logic [9:0]       iGreen,
    input  logic [9:0]       iBlue,
    output logic             oRequest,
    output logic [CNT_W-1:0] oCurrent_X,
    output logic [CNT_W-1:0] oCurrent_Y,
    output logic [9:0]       oVGA_R,
    output logic [9:0]       oVGA_G,
    output logic [9:0]       oVGA_B,
    output logic             oVGA_HS,
    output logic             oVGA_VS,
    output logic             oVGA_BLANK_N,
    output logic             oVGA_SYNC_N,
    output logic             oFrame_Start
);

    logic       hs0_n, vs0_n;
    logic       req1_q, hs1_n_q, vs1_n_q;
    logic       blank_n_q, blank_n_d, hs_n_q, hs_n_d, vs_n_q, vs_n_d;
    logic [9:0] r_q, r_d, g_q, g_d, b_q, b_d;

    vga_sync_gen #(
        .H_SYNC  (H_SYNC),
        .H_BACK  (H_BACK),
        .H_ACT   (H_ACT),
        .H_FRONT (H_FRONT),
        .V_SYNC  (V_SYNC),
        .V_BACK  (V_BACK),
        .V_ACT   (V_ACT),
        .V_FRONT (V_FRONT)
    ) u_sync_gen (
        .clk_i         (iCLK),
        .rst_ni        (iRST_N),
        .req_o         (oRequest),
        .x_o           (oCurrent_X),
        .y_o           (oCurrent_Y),
        .hs_n_o        (hs0_n),
        .vs_n_o        (vs0_n),
        .frame_start_o (oFrame_Start)
    );

    // Stage 2: upstream data is only accepted for cycles that were requested.
    always_comb begin
        r_d       = req1_q ? iRed   : '0;
        g_d       = req1_q ? iGreen : '0;
        b_d       = req1_q ? iBlue  : '0;
        blank_n_d = req1_q;
        hs_n_d    = hs1_n_q;
        vs_n_d    = vs1_n_q;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            req1_q    <= 1'b0;
            hs1_n_q   <= 1'b1;
            vs1_n_q   <= 1'b1;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            blank_n_q <= 1'b0;
            hs_n_q    <= 1'b1;
            vs_n_q    <= 1'b1;
        end else begin
            req1_q    <= oRequest;
            hs1_n_q   <= hs0_n;
            vs1_n_q   <= vs0_n;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            blank_n_q <= blank_n_d;
            hs_n_q    <= hs_n_d;
            vs_n_q    <= vs_n_d;
        end
    end

    assign oVGA_R       = r_q;
    assign oVGA_G       = g_q;
    assign oVGA_B       = b_q;
    assign oVGA_HS      = hs_n_q;
    assign oVGA_VS      = vs_n_q;
    assign oVGA_BLANK_N = blank_n_q;
    assign oVGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_out_ctrl.sv
// Directed bench for vga_out_ctrl; vertical timing is shortened to keep frames
// short, horizontal timing stays at the 800-clock default line.
module tb_vga_out_ctrl;

    localparam int V_S       = 2;
    localparam int V_B       = 3;
    localparam int V_A       = 4;
    localparam int V_F       = 2;
    localparam int LINE      = 800;
    localparam int FRAME     = LINE * (V_S + V_B + V_A + V_F);
    localparam int FIRST_REQ = (V_S + V_B) * LINE + 144;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic [9:0]  iRed, iGreen, iBlue;
    logic        oRequest;
    logic [10:0] oCurrent_X, oCurrent_Y;
    logic [9:0]  oVGA_R, oVGA_G, oVGA_B;
    logic        oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_SYNC_N, oFrame_Start;

    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;
    logic req_h1 = 1'b0;
    logic req_h2 = 1'b0;
    bit   ramp_mode = 1'b0;

    vga_out_ctrl #(
        .V_SYNC  (V_S),
        .V_BACK  (V_B),
        .V_ACT   (V_A),
        .V_FRONT (V_F)
    ) dut (
        .iCLK         (iCLK),
        .iRST_N       (iRST_N),
        .iRed         (iRed),
        .iGreen       (iGreen),
        .iBlue        (iBlue),
        .oRequest     (oRequest),
        .oCurrent_X   (oCurrent_X),
        .oCurrent_Y   (oCurrent_Y),
        .oVGA_R       (oVGA_R),
        .oVGA_G       (oVGA_G),
        .oVGA_B       (oVGA_B),
        .oVGA_HS      (oVGA_HS),
        .oVGA_VS      (oVGA_VS),
        .oVGA_BLANK_N (oVGA_BLANK_N),
        .oVGA_SYNC_N  (oVGA_SYNC_N),
        .oFrame_Start (oFrame_Start)
    );

    always #5 iCLK = ~iCLK;

    // Advance one clock; sample 1 time unit after the edge. In ramp mode the
    // upstream model returns the previous cycle's X as red data.
    task automatic tick();
        logic        r0;
        logic [10:0] x0;
        r0 = oRequest;
        x0 = oCurrent_X;
        @(posedge iCLK);
        #1;
        cycle++;
        req_h2 = req_h1;
        req_h1 = r0;
        if (ramp_mode) iRed = x0[9:0];
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (oRequest !== 1'b0 || oCurrent_X !== 11'd0 || oCurrent_Y !== 11'd0) begin
            errors++;
            $display("FAIL %s_req_xy: got req=%b x=%0d y=%0d want 0 0 0", tag, oRequest,
                     oCurrent_X, oCurrent_Y);
        end
        checks++;
        if ({oVGA_R, oVGA_G, oVGA_B} !== 30'd0) begin
            errors++;
            $display("FAIL %s_rgb: got %h %h %h want 0 0 0", tag, oVGA_R, oVGA_G, oVGA_B);
        end
        checks++;
        if (oVGA_HS !== 1'b1 || oVGA_VS !== 1'b1) begin
            errors++;
            $display("FAIL %s_sync: got hs=%b vs=%b want 1 1", tag, oVGA_HS, oVGA_VS);
        end
        checks++;
        if (oVGA_BLANK_N !== 1'b0 || oFrame_Start !== 1'b0 || oVGA_SYNC_N !== 1'b0) begin
            errors++;
            $display("FAIL %s_blank_fs: got blank_n=%b fs=%b sync_n=%b want 0 0 0", tag,
                     oVGA_BLANK_N, oFrame_Start, oVGA_SYNC_N);
        end
    endtask

    task automatic test_reset();
        iRST_N = 1'b0;
        iRed   = 10'h3FF;
        iGreen = 10'h155;
        iBlue  = 10'h0AA;
        repeat (3) tick();
        check_reset_outputs("reset");
        iRST_N = 1'b1;
        cycle  = -1;
    endtask

    task automatic test_frame_start();
        tick();
        checks++;
        if (oFrame_Start !== 1'b1 || oRequest !== 1'b0 || oVGA_HS !== 1'b1) begin
            errors++;
            $display("FAIL fs_cycle0: got fs=%b req=%b hs=%b want 1 0 1", oFrame_Start,
                     oRequest, oVGA_HS);
        end
        tick();
        checks++;
        if (oFrame_Start !== 1'b0 || oVGA_HS !== 1'b1) begin
            errors++;
            $display("FAIL fs_cycle1: got fs=%b hs=%b want 0 1", oFrame_Start, oVGA_HS);
        end
        tick();
        checks++;
        if (oVGA_HS !== 1'b0 || oVGA_VS !== 1'b0) begin
            errors++;
            $display("FAIL sync_cycle2: got hs=%b vs=%b want 0 0", oVGA_HS, oVGA_VS);
        end
    endtask

    task automatic test_first_request();
        while (!oRequest && cycle < FIRST_REQ + 10) tick();
        checks++;
        if (cycle !== FIRST_REQ || oRequest !== 1'b1) begin
            errors++;
            $display("FAIL first_req_cycle: got cycle=%0d req=%b want %0d 1", cycle, oRequest,
                     FIRST_REQ);
        end
        checks++;
        if (oCurrent_X !== 11'd0 || oCurrent_Y !== 11'd0) begin
            errors++;
            $display("FAIL first_req_xy: got x=%0d y=%0d want 0 0", oCurrent_X, oCurrent_Y);
        end
    endtask

    task automatic test_line();
        int          req_cnt = 0;
        int          hs_low  = 0;
        logic [10:0] last_x  = '0;
        logic [29:0] exp_rgb;
        for (int i = 0; i < LINE; i++) begin
            exp_rgb = req_h2 ? {10'h3FF, 10'h155, 10'h0AA} : 30'd0;
            checks++;
            if ({oVGA_R, oVGA_G, oVGA_B} !== exp_rgb || oVGA_BLANK_N !== req_h2) begin
                errors++;
                $display("FAIL line_data@%0d: got rgb=%h blank_n=%b want rgb=%h blank_n=%b",
                         cycle, {oVGA_R, oVGA_G, oVGA_B}, oVGA_BLANK_N, exp_rgb, req_h2);
            end
            if (oRequest) begin
                req_cnt++;
                last_x = oCurrent_X;
            end
            if (!oVGA_HS) hs_low++;
            tick();
        end
        checks++;
        if (req_cnt != 640) begin
            errors++;
            $display("FAIL line_req_count: got %0d want 640", req_cnt);
        end
        checks++;
        if (hs_low != 96) begin
            errors++;
            $display("FAIL line_hs_low: got %0d want 96", hs_low);
        end
        checks++;
        if (last_x !== 11'd639) begin
            errors++;
            $display("FAIL line_last_x: got %0d want 639", last_x);
        end
        checks++;
        if (oRequest !== 1'b1 || oCurrent_X !== 11'd0 || oCurrent_Y !== 11'd1) begin
            errors++;
            $display("FAIL line_period: got req=%b x=%0d y=%0d want 1 0 1", oRequest,
                     oCurrent_X, oCurrent_Y);
        end
    endtask

    task automatic test_frame();
        int lines = 0;
        int vs_low = 0;
        int req_total = 0;
        int bad = 0;
        while (!oFrame_Start && cycle < FRAME + 10) tick();
        checks++;
        if (cycle !== FRAME) begin
            errors++;
            $display("FAIL frame_period: got fs at cycle %0d want %0d", cycle, FRAME);
        end
        for (int i = 0; i < FRAME; i++) begin
            if (oRequest) req_total++;
            if (oRequest && oCurrent_X == 11'd0) lines++;
            if (!oVGA_VS) vs_low++;
            if (oVGA_BLANK_N !== req_h2 ||
                oVGA_R !== (req_h2 ? 10'h3FF : 10'd0)) bad++;
            tick();
        end
        checks++;
        if (lines != V_A || req_total != 640 * V_A) begin
            errors++;
            $display("FAIL frame_active: got lines=%0d reqs=%0d want %0d %0d", lines, req_total,
                     V_A, 640 * V_A);
        end
        checks++;
        if (vs_low != V_S * LINE) begin
            errors++;
            $display("FAIL frame_vs_low: got %0d want %0d", vs_low, V_S * LINE);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL frame_data: got %0d misaligned cycles want 0", bad);
        end
        checks++;
        if (oFrame_Start !== 1'b1) begin
            errors++;
            $display("FAIL frame_next_fs: got %b want 1 at cycle %0d", oFrame_Start, cycle);
        end
    endtask

    task automatic test_ramp();
        int base;
        base = cycle;
        ramp_mode = 1'b1;
        while (!oVGA_BLANK_N && cycle < base + FIRST_REQ + 10) tick();
        checks++;
        if (cycle !== base + FIRST_REQ + 2 || oVGA_R !== 10'd0) begin
            errors++;
            $display("FAIL ramp_first: got cycle=%0d r=%0d want %0d 0", cycle, oVGA_R,
                     base + FIRST_REQ + 2);
        end
        for (int i = 1; i < 640; i++) begin
            tick();
            checks++;
            if (oVGA_R !== 10'(i) || oVGA_BLANK_N !== 1'b1) begin
                errors++;
                $display("FAIL ramp_step: got r=%0d blank_n=%b want %0d 1", oVGA_R,
                         oVGA_BLANK_N, i);
            end
        end
        tick();
        checks++;
        if (oVGA_R !== 10'd0 || oVGA_BLANK_N !== 1'b0) begin
            errors++;
            $display("FAIL ramp_end: got r=%0d blank_n=%b want 0 0", oVGA_R, oVGA_BLANK_N);
        end
        ramp_mode = 1'b0;
        iRed = 10'h3FF;
    endtask

    task automatic test_mid_reset();
        int bad = 0;
        int start;
        start = cycle;
        while (!oFrame_Start && cycle < start + FRAME + 10) tick();
        repeat (5 * LINE + 400) tick();
        checks++;
        if (oRequest !== 1'b1 || oCurrent_X !== 11'd256 || oCurrent_Y !== 11'd0) begin
            errors++;
            $display("FAIL pre_reset_pos: got req=%b x=%0d y=%0d want 1 256 0", oRequest,
                     oCurrent_X, oCurrent_Y);
        end
        #2;
        iRST_N = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        tick();
        tick();
        iRST_N = 1'b1;
        cycle  = -1;
        tick();
        checks++;
        if (oFrame_Start !== 1'b1 || oRequest !== 1'b0) begin
            errors++;
            $display("FAIL restart_fs: got fs=%b req=%b want 1 0", oFrame_Start, oRequest);
        end
        while (!oVGA_BLANK_N && cycle < FIRST_REQ + 10) begin
            if ({oVGA_R, oVGA_G, oVGA_B} !== 30'd0) bad++;
            tick();
        end
        checks++;
        if (bad != 0 || cycle !== FIRST_REQ + 2 || oVGA_R !== 10'h3FF) begin
            errors++;
            $display("FAIL restart_first_pixel: got cycle=%0d r=%h stray=%0d want %0d 3ff 0",
                     cycle, oVGA_R, bad, FIRST_REQ + 2);
        end
    endtask

    initial begin
        test_reset();
        test_frame_start();
        test_first_request();
        test_line();
        test_frame();
        test_ramp();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
